// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: operation encodings, control states and default latencies
package mult_div_unit_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_NONE7 = 3'd7
  } mdop_e;
  typedef enum logic {S_IDLE, S_BUSY} state_e;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit; results are computed at accept and
// committed to HI/LO after a fixed busy latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDop,
  input  logic             Start,
  input  logic             HILOsel,
  output logic             Busy,
  output logic [WIDTH-1:0] Out
);
  localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  state_e state, state_nxt;
  mdop_e op;
  logic [3:0] cnt;
  logic [WIDTH-1:0] hi, lo, stage_hi, stage_lo;
  logic stage_wr;
  logic accept, is_mul, is_div, long_op, b_zero, div_ovf;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic signed [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0] div_u, q_s, r_s, q_u, r_u, res_hi, res_lo;
  always_comb begin
    op = mdop_e'(MDop);
    is_mul = op == MD_MULT || op == MD_MULTU;
    is_div = op == MD_DIV || op == MD_DIVU;
    long_op = is_mul || is_div;
    accept = reset && Start && state == S_IDLE && op != MD_NONE && op != MD_NONE7;
  end
  // Divisor is forced to 1 for /0 (result discarded) and for MIN/-1, where
  // A/1 yields exactly the required LO=MIN, HI=0 without overflow.
  assign b_zero = B == '0;
  assign div_ovf = A == MIN_NEG && B == '1;
  assign sa = A;
  assign sb = (b_zero || div_ovf) ? ONE : B;
  assign div_u = b_zero ? ONE : B;
  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign q_s = sa / sb;
  assign r_s = sa % sb;
  assign q_u = A / div_u;
  assign r_u = A % div_u;
  always_comb begin
    res_hi = op == MD_MULT ? prod_s[2*WIDTH-1:WIDTH] : op == MD_MULTU ? prod_u[2*WIDTH-1:WIDTH] : op == MD_DIV ? r_s : r_u;
    res_lo = op == MD_MULT ? prod_s[WIDTH-1:0] : op == MD_MULTU ? prod_u[WIDTH-1:0] : op == MD_DIV ? q_s : q_u;
  end
  always_ff @(posedge clk)
    if (!reset) state <= S_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == S_IDLE ? (accept && long_op ? S_BUSY : S_IDLE) : (cnt == '0 ? S_IDLE : S_BUSY);
  always_comb begin
    Busy = state == S_BUSY;
    Out = HILOsel ? hi : lo;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      stage_hi <= '0;
      stage_lo <= '0;
      stage_wr <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (accept) begin
      if (long_op) begin
        cnt <= is_mul ? MUL_LOAD : DIV_LOAD;
        stage_hi <= res_hi;
        stage_lo <= res_lo;
        stage_wr <= !(is_div && b_zero);
      end
      if (op == MD_MTHI) hi <= A;
      if (op == MD_MTLO) lo <= A;
    end else if (state == S_BUSY) begin
      if (cnt == '0) begin
        if (stage_wr) begin
          hi <= stage_hi;
          lo <= stage_lo;
        end
      end else cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit (32-bit default
// instance plus an 8-bit single-cycle-multiply instance).
module tb_mult_div_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int cyc;
    string tag;
  } exp_t;
  localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
                         OP_DIVU = 3'b100, OP_MTHI = 3'b101, OP_MTLO = 3'b110;
  exp_t sb[$];
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0, start = 1'b0, hsel = 1'b0, busy;
  logic [2:0] mdop = 3'd0;
  logic [31:0] a = '0, b = '0, out;
  logic reset8 = 1'b0, start8 = 1'b0, hsel8 = 1'b0, busy8;
  logic [2:0] mdop8 = 3'd0;
  logic [7:0] a8 = '0, b8 = '0, out8;
  logic [31:0] m_hi = '0, m_lo = '0;
  int errors = 0, checks = 0;

  mult_div_unit dut (.clk(clk), .reset(reset), .A(a), .B(b), .MDop(mdop), .Start(start),
                     .HILOsel(hsel), .Busy(busy), .Out(out));
  mult_div_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
    .clk(clk), .reset(reset8), .A(a8), .B(b8), .MDop(mdop8), .Start(start8),
    .HILOsel(hsel8), .Busy(busy8), .Out(out8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    hsel = 1'b0;
    #1 l = out;
    hsel = 1'b1;
    #1 h = out;
    hsel = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    mdop = op;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    mdop = 3'd0;
  endtask

  task automatic wait_done();
    exp_t e;
    int n = 0;
    logic stable = 1'b1;
    logic [31:0] h, l;
    forever begin
      @(negedge clk);
      if (!busy || n > 40) break;
      n++;
      if (out !== m_lo) stable = 1'b0;
    end
    start = 1'b0;
    mdop = 3'd0;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_busy_cycles"}, n, e.cyc);
    chk({e.tag, "_out_stable"}, {31'd0, stable}, 32'd1);
    read_hilo(h, l);
    chk({e.tag, "_hi"}, h, e.hi);
    chk({e.tag, "_lo"}, l, e.lo);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic long_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                         input int cyc);
    sb.push_back('{hi: ehi, lo: elo, cyc: cyc, tag: tag});
    issue(op, av, bv);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] h, l, ra, rb;
    longint p;
    longint unsigned pu;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    chk("reset_hi", h, 32'd0);
    chk("reset_lo", l, 32'd0);
    reset = 1'b1;
    long_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    long_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    long_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    long_op("divu_zero", OP_DIVU, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    long_op("div_zero", OP_DIV, 32'd99, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    long_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    long_op("divu_big", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 10);
    long_op("div_negdivisor", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    long_op("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5);
    sb.push_back('{hi: 32'd0, lo: 32'd42, cyc: 5, tag: "mult_busy_mthi"});
    issue(OP_MULT, 32'd7, 32'd6);
    mdop = OP_MTHI;
    a = 32'h12345678;
    start = 1'b1;
    wait_done();
    issue(OP_MTHI, 32'h12345678, 32'd0);
    @(negedge clk);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    chk("mthi_hi", h, 32'h12345678);
    chk("mthi_lo_kept", l, 32'd42);
    m_hi = 32'h12345678;
    issue(OP_MTLO, 32'hCAFEF00D, 32'd0);
    @(negedge clk);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    chk("mtlo_lo", l, 32'hCAFEF00D);
    m_lo = 32'hCAFEF00D;
    issue(3'b111, 32'hDEADBEEF, 32'd3);
    @(negedge clk);
    chk("none7_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    chk("none7_hi", h, m_hi);
    chk("none7_lo", l, m_lo);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 0) rb = 32'd5;
      case (i)
        0: begin
          p = longint'($signed(ra)) * longint'($signed(rb));
          long_op("rand_mult", OP_MULT, ra, rb, p[63:32], p[31:0], 5);
        end
        1: begin
          pu = longint'({32'd0, ra}) * longint'({32'd0, rb});
          long_op("rand_multu", OP_MULTU, ra, rb, pu[63:32], pu[31:0], 5);
        end
        2: begin
          p = longint'($signed(ra)) / longint'($signed(rb));
          pu = longint'($signed(ra)) % longint'($signed(rb));
          long_op("rand_div", OP_DIV, ra, rb, pu[31:0], p[31:0], 10);
        end
        default: long_op("rand_divu", OP_DIVU, ra, rb, ra % rb, ra / rb, 10);
      endcase
    end
    issue(OP_MULT, 32'd5, 32'd5);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    chk("abort_hi", h, 32'd0);
    chk("abort_lo", l, 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_late_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    chk("abort_late_hi", h, 32'd0);
    chk("abort_late_lo", l, 32'd0);
    begin
      int n = 0;
      @(negedge clk);
      reset8 = 1'b1;
      mdop8 = OP_MULT;
      a8 = 8'h80;
      b8 = 8'h80;
      start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      mdop8 = 3'd0;
      forever begin
        @(negedge clk);
        if (!busy8 || n > 20) break;
        n++;
      end
      chk("w8_busy_cycles", n, 32'd1);
      hsel8 = 1'b1;
      #1 chk("w8_hi", {24'd0, out8}, 32'h40);
      hsel8 = 1'b0;
      #1 chk("w8_lo", {24'd0, out8}, 32'h00);
      mdop8 = OP_MTLO;
      a8 = 8'h55;
      start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      mdop8 = 3'd0;
      @(negedge clk);
      chk("w8_mtlo_busy", {31'd0, busy8}, 32'd0);
      chk("w8_mtlo_lo", {24'd0, out8}, 32'h55);
      hsel8 = 1'b1;
      #1 chk("w8_mtlo_hi_kept", {24'd0, out8}, 32'h40);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width in bits.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU (legal range 1..15).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU (legal range 1..15).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port A  input  WIDTH  operand 1 (dividend/multiplicand, or MTHI/MTLO source).
REQ-007 SHALL have port B  input  WIDTH  operand 2 (divisor/multiplier).
REQ-008 SHALL have port MDop  input  3  operation code: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NONE.
REQ-009 SHALL have port Start  input  1  one-cycle qualifier for MDop.
REQ-010 SHALL have port HILOsel  input  1  output select: 1 = HI, 0 = LO.
REQ-011 SHALL have port Busy  output  1  registered; high while a multiply/divide is in flight.
REQ-012 SHALL have port Out  output  WIDTH  combinational: HILOsel ? HI : LO.

Function
REQ-013 SHALL accept an operation only on a cycle with Start=1, Busy=0 and MDop not NONE; all other cycles leave state unchanged.
REQ-014 SHALL, on accepting MULT/MULTU/DIV/DIVU, capture the full result in internal staging registers and set Busy=1 from the next edge.
REQ-015 SHALL hold Busy=1 for exactly MULT_CYCLES (multiply) or DIV_CYCLES (divide) cycles, then write HI/LO and set Busy=0 on the same edge.
REQ-016 SHALL make the new HI/LO visible on Out in the first cycle in which Busy=0.
REQ-017 SHALL compute MULT as signed WIDTHxWIDTH -> 2*WIDTH with HI = upper half and LO = lower half; MULTU SHALL do the same unsigned.
REQ-018 SHALL compute DIV as signed with LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign; DIVU SHALL do the same unsigned.
REQ-019 SHALL, for DIV with A = most-negative and B = -1, produce LO = most-negative and HI = 0, with no error indication.
REQ-020 SHALL, for DIV/DIVU with B = 0, still run the full DIV_CYCLES busy period and leave HI and LO unchanged.
REQ-021 SHALL execute MTHI (HI<=A) and MTLO (LO<=A) in one cycle, visible on Out the next cycle, with Busy staying 0.
REQ-022 SHALL ignore Start while Busy=1, regardless of MDop, including MTHI/MTLO; the in-flight operation SHALL be unaffected.
REQ-023 SHALL accept a new operation in the cycle Busy has just fallen, i.e. back-to-back operations separated by zero idle cycles.
REQ-024 SHALL not change Out during Busy except via HILOsel; Out reflects committed HI/LO only.

Reset
REQ-025 SHALL, when reset=0 at a rising edge, set HI=0, LO=0, Busy=0, clear the cycle counter and the staging registers.
REQ-026 SHALL, if reset is asserted mid-operation, abort that operation with no HI/LO commit; Start is ignored in any cycle with reset=0.

Structure
REQ-027 SHALL take the MDop encodings and the default latencies from the shared project package/header, not from literals local to this module.
REQ-028 SHALL be a single module with one down-counter (4 bits), an IDLE/BUSY control state, staging registers, and HI/LO; no sub-module.
REQ-029 SHALL use no multicycle-path constraints; the * and / operators SHALL sit in the accept cycle feeding the staging registers.

Verification
REQ-030 SHALL cover: MULT A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 SHALL cover: MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 SHALL cover: DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU with B=0 -> HI/LO unchanged after 10 busy cycles.
REQ-033 SHALL cover: MTHI A=0x12345678 with Start during Busy -> ignored; repeated after Busy falls -> Out(HILOsel=1)=0x12345678 next cycle.
REQ-034 SHALL cover: MULT started, reset=0 at busy cycle 3 -> Busy=0, HI=LO=0 next cycle, no later commit.
REQ-035 SHALL cover: WIDTH=8, MULT_CYCLES=1: MULT 0x80 x 0x80 -> Busy one cycle, HI=0x40, LO=0x00; immediate back-to-back MTLO 0x55 accepted -> LO=0x55.
